branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage dynamic branch predictor paired with the execute-stage branch decision logic. It looks up the fetch PC in a direct-mapped branch target buffer with 2-bit saturating counters and supplies a predicted next PC. It carries each prediction alongside the instruction to E. There it compares the prediction with the resolved outcome, flags mispredictions with the corrected PC, and trains the table.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, 4..256
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden
- i_clk  in  1  pipeline clock
- i_rst  in  1  asynchronous, active-high reset
- i_pc_f  in  32  fetch PC
- o_pred_taken_f  out  1  prediction: taken
- o_pred_next_pc_f  out  32  predicted next PC: target if taken, else i_pc_f+4
- i_stall_d  in  1  hold the F->D prediction register
- i_flush_d  in  1  clear the F->D prediction register
- i_flush_e  in  1  clear the D->E prediction register
- i_pc_e  in  32  PC of the instruction in E
- i_branch_e  in  1  E holds a conditional branch
- i_branch_taken_e  in  1  resolved outcome from the branch decision unit
- i_target_e  in  32  resolved branch target (PC+imm)
- o_mispredict_e  out  1  prediction in E was wrong; the hazard unit flushes D and E
- o_redirect_pc_e  out  32  corrected fetch PC, valid when o_mispredict_e=1

## Operation
- Entry fields: valid, tag = pc[31:2+IDX_W], target[31:0], ctr[1:0]. Index = pc[IDX_W+1:2].
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Taken is inc; not-taken is dec; both saturate at 11/00.
- Lookup (combinational): hit = valid && tag match. o_pred_taken_f = hit && ctr[1]. The predicted target is the entry target.
- Shadow pipeline: {pred_taken, pred_target} registered F->D, then D->E.
  - F->D holds on i_stall_d and clears on i_flush_d. Flush has priority over stall.
  - D->E clears on i_flush_e.
  - A cleared register reads as not-taken, target 0.
- E-stage check (combinational):
  - Branch, pred NT, actual T: mispredict, redirect i_target_e.
  - Branch, pred T, actual NT: mispredict, redirect i_pc_e+4.
  - Branch, pred T, actual T, predicted target != i_target_e: mispredict, redirect i_target_e.
  - Not a branch, pred T (alias): mispredict, redirect i_pc_e+4.
  - All other cases: o_mispredict_e=0, o_redirect_pc_e=i_pc_e+4.
- Update at the clock edge closing the E cycle:
  - Branch, tag hit: update the counter, write target=i_target_e.
  - Branch, tag miss: allocate entry with valid=1, new tag, target. ctr=10 if taken, else 01.
  - Not a branch, pred T (alias): clear that entry's valid bit.
- The E stage never stalls, so each branch updates exactly once.

## Timing
- Prediction has zero-cycle latency: the outputs are a combinational function of i_pc_f and the table.
- A table write becomes visible to a lookup on the next cycle. A same-cycle read of the index being written returns the old contents.
- A prediction reaches E two edges after F, absent stalls and flushes.
- Reset is asynchronous and clears every valid bit, every counter to 01, and both shadow registers.
- Outputs after reset:
  - o_pred_taken_f=0
  - o_pred_next_pc_f=i_pc_f+4
  - o_mispredict_e=0
  - o_redirect_pc_e=i_pc_e+4
- Reset asserted mid-operation discards all training. No partial update survives.
- When i_flush_e coincides with a branch in E, that branch still updates the table. The flush affects only the next D->E load.

## Structure
- Constants.vh:
  - counter encodings (CTR_SNT/WNT/WT/ST)
  - default ENTRIES
- Sub-module bp_table: storage, lookup port and update port, with reset clear.
- The top level holds the shadow registers, the E-stage compare and the redirect mux.

## Test plan
- Reset, then i_pc_f=0x100 -> o_pred_taken_f=0, o_pred_next_pc_f=0x104.
- Branch at 0x100, taken to 0x80, cold -> mispredict, redirect 0x80. Next fetch of 0x100 predicts taken to 0x80 (ctr=10).
- Same branch resolves not-taken twice -> first: mispredict, redirect 0x104, ctr=01. Second: no mispredict, ctr=00.
- Aliasing PC 0x140 (same index, ENTRIES=16), non-branch, while entry is T -> mispredict, redirect 0x144, entry invalidated.
- i_stall_d=1 for 2 cycles, then release -> the held prediction reaches E unchanged. With i_flush_d=1 and i_stall_d=1 together -> the register clears.
- Assert i_rst while a trained branch is in E -> no update lands, and every lookup misses afterwards.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared types and constants for the fetch-stage branch predictor:
//   - 2-bit saturating counter encodings (ctr_e)
//   - default BTB depth
//   - the prediction record carried down the shadow pipeline (pred_t)
//   - ctr_next(): saturating counter update
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam int DEFAULT_ENTRIES = 16;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,  // strongly not-taken
        CTR_WNT = 2'b01,  // weakly not-taken
        CTR_WT  = 2'b10,  // weakly taken
        CTR_ST  = 2'b11   // strongly taken
    } ctr_e;

    // Prediction record travelling F -> D -> E alongside the instruction.
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_t;

    // Taken increments, not-taken decrements, both saturate.
    function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
        if (taken) begin
            ctr_next = (cur == CTR_ST) ? CTR_ST : ctr_e'(cur + 2'd1);
        end else begin
            ctr_next = (cur == CTR_SNT) ? CTR_SNT : ctr_e'(cur - 2'd1);
        end
    endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// -----------------------------------------------------------------------------
// bp_table
// Direct-mapped branch target buffer with one 2-bit counter per entry.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   lookup_word         fetch PC word address (pc[31:2])
//   lookup_hit          entry valid and tag matches
//   lookup_ctr          counter of the indexed entry
//   lookup_target       stored target of the indexed entry
//   upd_word            E-stage PC word address (pc[31:2])
//   upd_branch          E holds a branch: train or allocate
//   upd_taken           resolved outcome
//   upd_target          resolved target
//   upd_invalidate      non-branch predicted taken: drop the entry
// Writes land on the clock edge; a same-cycle lookup sees the old contents.
// -----------------------------------------------------------------------------
module bp_table
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_word,
    output logic        lookup_hit,
    output ctr_e        lookup_ctr,
    output logic [31:0] lookup_target,
    input  logic [29:0] upd_word,
    input  logic        upd_branch,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_invalidate
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic              valid_q  [ENTRIES];
    ctr_e              ctr_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];

    logic [IDX_W-1:0] lookup_idx, upd_idx;
    logic [TAG_W-1:0] lookup_tag, upd_tag;
    logic             upd_hit;

    assign lookup_idx = lookup_word[IDX_W-1:0];
    assign lookup_tag = lookup_word[29:IDX_W];
    assign upd_idx    = upd_word[IDX_W-1:0];
    assign upd_tag    = upd_word[29:IDX_W];

    assign lookup_hit    = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign lookup_ctr    = ctr_q[lookup_idx];
    assign lookup_target = target_q[lookup_idx];

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Control state: valid bits and counters must come up known.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (upd_branch) begin
            valid_q[upd_idx] <= 1'b1;
            // A miss allocates at the weak state matching the first outcome.
            ctr_q[upd_idx]   <= upd_hit ? ctr_next(ctr_q[upd_idx], upd_taken)
                                        : (upd_taken ? CTR_WT : CTR_WNT);
        end else if (upd_invalidate) begin
            valid_q[upd_idx] <= 1'b0;
        end
    end

    // NOTE: tag/target are payload guarded by valid, so they carry no reset and
    // can map onto plain RAM; keep them out of the reset block above.
    always_ff @(posedge clk) begin
        if (upd_branch) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Fetch-stage BTB prediction plus execute-stage misprediction check.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_pc_f               fetch PC
//   o_pred_taken_f       predicted taken (combinational on i_pc_f)
//   o_pred_next_pc_f     predicted next fetch PC
//   i_stall_d            hold the F->D prediction register
//   i_flush_d            clear the F->D prediction register (beats stall)
//   i_flush_e            clear the D->E prediction register
//   i_pc_e               PC of the instruction in E
//   i_branch_e           E holds a conditional branch
//   i_branch_taken_e     resolved outcome
//   i_target_e           resolved branch target
//   o_mispredict_e       prediction in E was wrong
//   o_redirect_pc_e      corrected fetch PC (i_pc_e+4 when no mispredict)
// -----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_f,
    output logic        o_pred_taken_f,
    output logic [31:0] o_pred_next_pc_f,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_flush_e,
    input  logic [31:0] i_pc_e,
    input  logic        i_branch_e,
    input  logic        i_branch_taken_e,
    input  logic [31:0] i_target_e,
    output logic        o_mispredict_e,
    output logic [31:0] o_redirect_pc_e
);

    logic        hit_f;
    ctr_e        ctr_f;
    logic [31:0] target_f;
    pred_t       pred_f, pred_d, pred_e;
    logic [31:0] pc_plus4_e;
    logic        alias_e;

    // A non-branch arriving with a taken prediction hit an aliased entry.
    assign alias_e = !i_branch_e && pred_e.taken;

    bp_table #(.ENTRIES(ENTRIES)) u_table (
        .clk            (i_clk),
        .rst            (i_rst),
        .lookup_word    (i_pc_f[31:2]),
        .lookup_hit     (hit_f),
        .lookup_ctr     (ctr_f),
        .lookup_target  (target_f),
        .upd_word       (i_pc_e[31:2]),
        .upd_branch     (i_branch_e),
        .upd_taken      (i_branch_taken_e),
        .upd_target     (i_target_e),
        .upd_invalidate (alias_e)
    );

    // Fetch-stage prediction.
    assign pred_f.taken     = hit_f && ctr_f[1];
    assign pred_f.target    = target_f;
    assign o_pred_taken_f   = pred_f.taken;
    assign o_pred_next_pc_f = pred_f.taken ? pred_f.target : i_pc_f + 32'd4;

    // F->D shadow register; flush wins over stall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pred_d <= '0;
        end else if (i_flush_d) begin
            pred_d <= '0;
        end else if (!i_stall_d) begin
            pred_d <= pred_f;
        end
    end

    // D->E shadow register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pred_e <= '0;
        end else if (i_flush_e) begin
            pred_e <= '0;
        end else begin
            pred_e <= pred_d;
        end
    end

    assign pc_plus4_e = i_pc_e + 32'd4;

    // E-stage compare and redirect mux.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch);
        // combinational logic uses blocking '=', registers above use '<='.
        o_mispredict_e  = 1'b0;
        o_redirect_pc_e = pc_plus4_e;
        if (i_branch_e) begin
            if (i_branch_taken_e) begin
                // Covers predicted NT and predicted T with a stale target.
                if (!pred_e.taken || (pred_e.target != i_target_e)) begin
                    o_mispredict_e  = 1'b1;
                    o_redirect_pc_e = i_target_e;
                end
            end else if (pred_e.taken) begin
                o_mispredict_e = 1'b1;
            end
        end else if (alias_e) begin
            o_mispredict_e = 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor (ENTRIES=16). Expected outputs are pushed
// into a scoreboard queue as each cycle's stimulus is driven and popped and
// compared once the combinational outputs have settled mid-cycle.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_next_pc_f;
    logic        stall_d, flush_d, flush_e;
    logic [31:0] pc_e;
    logic        branch_e, branch_taken_e;
    logic [31:0] target_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;

    int checks   = 0;
    int failures = 0;

    typedef enum {K_PT, K_NPC, K_MIS, K_RED} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] value;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pc_f           (pc_f),
        .o_pred_taken_f   (pred_taken_f),
        .o_pred_next_pc_f (pred_next_pc_f),
        .i_stall_d        (stall_d),
        .i_flush_d        (flush_d),
        .i_flush_e        (flush_e),
        .i_pc_e           (pc_e),
        .i_branch_e       (branch_e),
        .i_branch_taken_e (branch_taken_e),
        .i_target_e       (target_e),
        .o_mispredict_e   (mispredict_e),
        .o_redirect_pc_e  (redirect_pc_e)
    );

    task automatic push(input kind_e k, input logic [31:0] v, input string tag);
        exp_t e;
        e.kind  = k;
        e.value = v;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic exp_f(input string tag, input logic pt, input logic [31:0] npc);
        push(K_PT, {31'b0, pt}, {tag, ".pred_taken_f"});
        push(K_NPC, npc, {tag, ".pred_next_pc_f"});
    endtask

    task automatic exp_e(input string tag, input logic mis, input logic [31:0] red);
        push(K_MIS, {31'b0, mis}, {tag, ".mispredict_e"});
        push(K_RED, red, {tag, ".redirect_pc_e"});
    endtask

    // Pop every pending expectation and compare against the live outputs.
    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_PT:    obs = {31'b0, pred_taken_f};
                K_NPC:   obs = pred_next_pc_f;
                K_MIS:   obs = {31'b0, mispredict_e};
                default: obs = redirect_pc_e;
            endcase
            checks++;
            assert (obs === e.value) else begin
                failures++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.value);
            end
        end
    endtask

    // Advance one clock; inputs return to an idle E stage with no hazards.
    task automatic tick();
        @(posedge clk);
        #1;
        stall_d        = 1'b0;
        flush_d        = 1'b0;
        flush_e        = 1'b0;
        branch_e       = 1'b0;
        branch_taken_e = 1'b0;
        pc_e           = 32'h600;
        target_e       = 32'h0;
    endtask

    task automatic settle();
        #3;
        check_sb();
    endtask

    task automatic br_e(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        branch_e       = 1'b1;
        pc_e           = pc;
        branch_taken_e = taken;
        target_e       = tgt;
    endtask

    task automatic mp_flush();
        flush_d = 1'b1;
        flush_e = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pc_f = 32'h100;
        stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
        branch_e = 1'b0; branch_taken_e = 1'b0;
        pc_e = 32'h600; target_e = 32'h0;
        #2;
        exp_f("reset", 1'b0, 32'h104);
        exp_e("reset", 1'b0, 32'h604);
        check_sb();
        @(negedge clk);
        rst = 1'b0;

        // Cold lookup and cold taken branch.
        tick(); pc_f = 32'h100; exp_f("c0", 0, 32'h104); exp_e("c0", 0, 32'h604); settle();
        tick(); pc_f = 32'h300; exp_f("c1", 0, 32'h304); exp_e("c1", 0, 32'h604); settle();
        tick(); pc_f = 32'h100; br_e(32'h100, 1, 32'h80); mp_flush();
        exp_f("cold_same_cycle", 0, 32'h104); exp_e("cold_taken", 1, 32'h80); settle();
        tick(); pc_f = 32'h100; exp_f("trained_t", 1, 32'h80); exp_e("c3", 0, 32'h604); settle();
        tick(); pc_f = 32'h104; exp_f("other_idx", 0, 32'h108); exp_e("c4", 0, 32'h604); settle();

        // First not-taken: predicted T in E, counter 10 -> 01.
        tick(); pc_f = 32'h100; br_e(32'h100, 0, 32'h80); mp_flush();
        exp_f("c5", 1, 32'h80); exp_e("nt_first", 1, 32'h104); settle();
        tick(); pc_f = 32'h100; exp_f("ctr_01", 0, 32'h104); exp_e("c6", 0, 32'h604); settle();
        tick(); pc_f = 32'h700; exp_f("c7", 0, 32'h704); exp_e("c7", 0, 32'h604); settle();

        // Second not-taken: predicted NT, correct; counter 01 -> 00.
        tick(); pc_f = 32'h100; br_e(32'h100, 0, 32'h80);
        exp_f("c8", 0, 32'h104); exp_e("nt_second", 0, 32'h104); settle();
        tick(); pc_f = 32'h100; exp_f("ctr_00", 0, 32'h104); exp_e("c9", 0, 32'h604); settle();

        // One taken from 00 only reaches 01: still predicts NT.
        tick(); pc_f = 32'h100; br_e(32'h100, 1, 32'h80); mp_flush();
        exp_f("c10", 0, 32'h104); exp_e("t_from_00", 1, 32'h80); settle();
        tick(); pc_f = 32'h100; exp_f("ctr_sat_low", 0, 32'h104); exp_e("c11", 0, 32'h604); settle();
        tick(); pc_f = 32'h100; br_e(32'h100, 1, 32'h80); mp_flush();
        exp_f("c12", 0, 32'h104); exp_e("t_from_01", 1, 32'h80); settle();

        // Alias: 0x140 shares index 0 with 0x100.
        tick(); pc_f = 32'h100; exp_f("ctr_10", 1, 32'h80); exp_e("c13", 0, 32'h604); settle();
        tick(); pc_f = 32'h300; exp_f("c14", 0, 32'h304); exp_e("c14", 0, 32'h604); settle();
        tick(); pc_f = 32'h100; pc_e = 32'h140; mp_flush();
        exp_f("c15", 1, 32'h80); exp_e("alias", 1, 32'h144); settle();
        tick(); pc_f = 32'h100; br_e(32'h100, 1, 32'h80); mp_flush();
        exp_f("invalidated", 0, 32'h104); exp_e("realloc", 1, 32'h80); settle();

        // Stall holds the F->D prediction (E gets bubbles meanwhile).
        tick(); pc_f = 32'h100; exp_f("alloc_wt", 1, 32'h80); exp_e("c17", 0, 32'h604); settle();
        tick(); pc_f = 32'h300; stall_d = 1; flush_e = 1;
        exp_f("c18", 0, 32'h304); exp_e("stall1", 0, 32'h604); settle();
        tick(); pc_f = 32'h300; stall_d = 1; flush_e = 1;
        exp_f("c19", 0, 32'h304); exp_e("stall2", 0, 32'h604); settle();
        tick(); pc_f = 32'h300; exp_f("c20", 0, 32'h304); exp_e("c20", 0, 32'h604); settle();
        tick(); pc_f = 32'h100; br_e(32'h100, 1, 32'h80);
        exp_f("c21", 1, 32'h80); exp_e("held_pred", 0, 32'h104); settle();

        // Predicted taken, actual taken, stale target.
        tick(); pc_f = 32'h300; exp_f("c22", 0, 32'h304); exp_e("c22", 0, 32'h604); settle();
        tick(); pc_f = 32'h100; br_e(32'h100, 1, 32'h90); mp_flush();
        exp_f("c23", 1, 32'h80); exp_e("bad_target", 1, 32'h90); settle();
        tick(); pc_f = 32'h100; exp_f("new_target", 1, 32'h90); exp_e("c24", 0, 32'h604); settle();

        // Flush and stall together: flush wins.
        tick(); pc_f = 32'h100; stall_d = 1; flush_d = 1; flush_e = 1;
        exp_f("c25", 1, 32'h90); exp_e("c25", 0, 32'h604); settle();
        tick(); pc_f = 32'h300; exp_f("c26", 0, 32'h304); exp_e("c26", 0, 32'h604); settle();
        tick(); pc_f = 32'h100; br_e(32'h100, 1, 32'h90); mp_flush();
        exp_f("c27", 1, 32'h90); exp_e("flush_over_stall", 1, 32'h90); settle();

        // Reset while a trained, mispredicting branch sits in E.
        tick(); pc_f = 32'h100; exp_f("c28", 1, 32'h90); exp_e("c28", 0, 32'h604); settle();
        tick(); pc_f = 32'h300; exp_f("c29", 0, 32'h304); exp_e("c29", 0, 32'h604); settle();
        tick(); pc_f = 32'h100; br_e(32'h100, 0, 32'h90);
        #1;
        exp_e("pre_reset", 1, 32'h104);
        check_sb();
        rst = 1'b1;
        #1;
        exp_f("mid_reset", 0, 32'h104);
        exp_e("mid_reset", 0, 32'h104);
        check_sb();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pc_f = 32'h100 + 32'(4 * i);
            exp_f($sformatf("post_reset_%0d", i), 0, 32'h104 + 32'(4 * i));
            exp_e($sformatf("post_reset_%0d", i), 0, 32'h604);
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
